// File: rtl/pe_conv_tap_unit_if.sv
// Stream bundle for the conv tap PE: ifmap input beat, psum result, and systolic forward.
// The master modport is the upstream/downstream environment; the slave modport is the PE.
interface pe_conv_tap_unit_if #(
    parameter int IFMAP_W = 8,
    parameter int PSUM_W  = 14
) ();
    logic               ifmap_valid;
    logic               ifmap_ready;
    logic [IFMAP_W-1:0] ifmap_in;
    logic [PSUM_W-1:0]  psum_in;
    logic [IFMAP_W-1:0] ifmap_shift_out;
    logic               ifmap_shift_vld;
    logic [PSUM_W-1:0]  psum_out;
    logic               psum_valid;
    logic               psum_ready;
    logic               sat_flag;

    modport master (
        output ifmap_valid, ifmap_in, psum_in, psum_ready,
        input  ifmap_ready, ifmap_shift_out, ifmap_shift_vld, psum_out, psum_valid, sat_flag
    );

    modport slave (
        input  ifmap_valid, ifmap_in, psum_in, psum_ready,
        output ifmap_ready, ifmap_shift_out, ifmap_shift_vld, psum_out, psum_valid, sat_flag
    );
endinterface

// File: rtl/pe_conv_tap_unit.sv
// NUM_TAPS-tap 1-D convolution MAC: shift window, 2-stage stallable pipeline
// (S1 = products + psum_in, S2 = saturated sum), signed/unsigned mode.
module pe_conv_tap_unit #(
    parameter int NUM_TAPS = 3,
    parameter int IFMAP_W  = 8,
    parameter int FILTR_W  = 4,
    parameter int PSUM_W   = 14
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        cfg_signed,
    input  logic                        filtr_load,
    input  logic [NUM_TAPS*FILTR_W-1:0] filtr_in,
    input  logic                        clear,
    output logic                        busy,
    pe_conv_tap_unit_if.slave           bus
);
    // state | meaning
    // IDLE  | no weights loaded since reset; ifmap not accepted
    // FILL  | window filling; results not yet issued
    // RUN   | every accepted sample issues one result
    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    localparam int PROD_W = IFMAP_W + FILTR_W;
    localparam int SUM_W  = PSUM_W + $clog2(NUM_TAPS) + 1;
    localparam int CNT_W  = $clog2(NUM_TAPS);
    localparam logic [SUM_W-1:0] U_MAX = {{(SUM_W-PSUM_W){1'b0}}, {PSUM_W{1'b1}}};
    localparam logic [SUM_W-1:0] S_MAX = {{(SUM_W-PSUM_W+1){1'b0}}, {(PSUM_W-1){1'b1}}};
    localparam logic [SUM_W-1:0] S_MIN = {{(SUM_W-PSUM_W+1){1'b1}}, {(PSUM_W-1){1'b0}}};

    state_t              state_q, state_d;
    logic [FILTR_W-1:0]  w_q [NUM_TAPS];
    logic [FILTR_W-1:0]  w_d [NUM_TAPS];
    logic [IFMAP_W-1:0]  x_q [NUM_TAPS];
    logic [IFMAP_W-1:0]  x_d [NUM_TAPS];
    logic [PROD_W-1:0]   prod_q [NUM_TAPS];
    logic [PROD_W-1:0]   prod_d [NUM_TAPS];
    logic                signed_q, signed_d;
    logic [CNT_W-1:0]    fill_cnt_q, fill_cnt_d;
    logic [PSUM_W-1:0]   s1_psum_q, s1_psum_d;
    logic                s1_vld_q, s1_vld_d;
    logic [PSUM_W-1:0]   psum_out_q, psum_out_d;
    logic                psum_valid_q, psum_valid_d;
    logic                sat_q, sat_d;
    logic [IFMAP_W-1:0]  shift_out_q, shift_out_d;
    logic                shift_vld_q, shift_vld_d;

    logic                stall, ifmap_ready, accept;
    logic [SUM_W-1:0]    sum_c;
    logic [PSUM_W-1:0]   clamp_c;
    logic                sat_c;

    // Low PROD_W bits of the extended product are exact in both modes.
    function automatic logic [PROD_W-1:0] mul_ext(input logic [IFMAP_W-1:0] x,
                                                  input logic [FILTR_W-1:0] w,
                                                  input logic sgn);
        logic [PROD_W-1:0] xe;
        logic [PROD_W-1:0] we;
        xe = {{FILTR_W{sgn & x[IFMAP_W-1]}}, x};
        we = {{IFMAP_W{sgn & w[FILTR_W-1]}}, w};
        return xe * we;
    endfunction

    function automatic logic [SUM_W-1:0] ext_prod(input logic [PROD_W-1:0] p, input logic sgn);
        return {{(SUM_W-PROD_W){sgn & p[PROD_W-1]}}, p};
    endfunction

    function automatic logic [SUM_W-1:0] ext_psum(input logic [PSUM_W-1:0] p, input logic sgn);
        return {{(SUM_W-PSUM_W){sgn & p[PSUM_W-1]}}, p};
    endfunction

    always_comb begin
        sum_c = ext_psum(s1_psum_q, signed_q);
        for (int k = 0; k < NUM_TAPS; k++) begin
            sum_c = sum_c + ext_prod(prod_q[k], signed_q);
        end
        clamp_c = sum_c[PSUM_W-1:0];
        sat_c   = 1'b0;
        if (signed_q) begin
            if ($signed(sum_c) > $signed(S_MAX)) begin
                clamp_c = S_MAX[PSUM_W-1:0];
                sat_c   = 1'b1;
            end else if ($signed(sum_c) < $signed(S_MIN)) begin
                clamp_c = S_MIN[PSUM_W-1:0];
                sat_c   = 1'b1;
            end
        end else if (sum_c > U_MAX) begin
            clamp_c = U_MAX[PSUM_W-1:0];
            sat_c   = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        x_d          = x_q;
        prod_d       = prod_q;
        signed_d     = signed_q;
        fill_cnt_d   = fill_cnt_q;
        s1_psum_d    = s1_psum_q;
        s1_vld_d     = s1_vld_q;
        psum_out_d   = psum_out_q;
        psum_valid_d = psum_valid_q;
        sat_d        = sat_q;
        shift_out_d  = shift_out_q;
        shift_vld_d  = shift_vld_q;

        stall       = psum_valid_q & ~bus.psum_ready;
        ifmap_ready = en & ~rst & (state_q != IDLE) & ~stall & ~filtr_load & ~clear;
        accept      = ifmap_ready & bus.ifmap_valid;

        if (en) begin
            if (filtr_load || clear) begin
                // Flush drops everything in flight; only filtr_load touches weights/mode.
                if (filtr_load) begin
                    for (int k = 0; k < NUM_TAPS; k++) begin
                        w_d[k] = filtr_in[k*FILTR_W +: FILTR_W];
                    end
                    signed_d = cfg_signed;
                    state_d  = FILL;
                end else if (state_q != IDLE) begin
                    state_d = FILL;
                end
                for (int k = 0; k < NUM_TAPS; k++) begin
                    x_d[k] = '0;
                end
                fill_cnt_d   = '0;
                s1_vld_d     = 1'b0;
                psum_valid_d = 1'b0;
                psum_out_d   = '0;
                sat_d        = 1'b0;
                shift_vld_d  = 1'b0;
            end else begin
                shift_vld_d = 1'b0;
                if (!stall) begin
                    psum_valid_d = s1_vld_q;
                    sat_d        = s1_vld_q & sat_c;
                    if (s1_vld_q) begin
                        psum_out_d = clamp_c;
                    end
                    s1_vld_d = 1'b0;
                end
                if (accept) begin
                    x_d[0] = bus.ifmap_in;
                    for (int k = 1; k < NUM_TAPS; k++) begin
                        x_d[k] = x_q[k-1];
                    end
                    for (int k = 0; k < NUM_TAPS; k++) begin
                        prod_d[k] = mul_ext(x_d[k], w_q[k], signed_q);
                    end
                    s1_psum_d   = bus.psum_in;
                    shift_out_d = x_q[NUM_TAPS-1];
                    shift_vld_d = (state_q == RUN);
                    if (state_q == RUN) begin
                        s1_vld_d = 1'b1;
                    end else if (fill_cnt_q == CNT_W'(NUM_TAPS-1)) begin
                        s1_vld_d = 1'b1;
                        state_d  = RUN;
                    end else begin
                        fill_cnt_d = fill_cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            signed_q     <= 1'b0;
            fill_cnt_q   <= '0;
            s1_psum_q    <= '0;
            s1_vld_q     <= 1'b0;
            psum_out_q   <= '0;
            psum_valid_q <= 1'b0;
            sat_q        <= 1'b0;
            shift_out_q  <= '0;
            shift_vld_q  <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                w_q[k]    <= '0;
                x_q[k]    <= '0;
                prod_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            signed_q     <= signed_d;
            fill_cnt_q   <= fill_cnt_d;
            s1_psum_q    <= s1_psum_d;
            s1_vld_q     <= s1_vld_d;
            psum_out_q   <= psum_out_d;
            psum_valid_q <= psum_valid_d;
            sat_q        <= sat_d;
            shift_out_q  <= shift_out_d;
            shift_vld_q  <= shift_vld_d;
            for (int k = 0; k < NUM_TAPS; k++) begin
                w_q[k]    <= w_d[k];
                x_q[k]    <= x_d[k];
                prod_q[k] <= prod_d[k];
            end
        end
    end

    assign bus.ifmap_ready     = ifmap_ready;
    assign bus.psum_out        = psum_out_q;
    assign bus.psum_valid      = psum_valid_q;
    assign bus.sat_flag        = sat_q;
    assign bus.ifmap_shift_out = shift_out_q;
    assign bus.ifmap_shift_vld = shift_vld_q;
    assign busy = (state_q != IDLE) | s1_vld_q | psum_valid_q;
endmodule

// File: tb/tb_pe_conv_tap_unit.sv
// Directed bench for pe_conv_tap_unit: basic MAC, saturation, stall, clear, reload, reset, enable.
module tb_pe_conv_tap_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        cfg_signed = 1'b0;
    logic        filtr_load = 1'b0;
    logic [11:0] filtr_in = '0;
    logic        clear = 1'b0;
    logic        busy;

    pe_conv_tap_unit_if #(.IFMAP_W(8), .PSUM_W(14)) bus ();

    pe_conv_tap_unit #(.NUM_TAPS(3), .IFMAP_W(8), .FILTR_W(4), .PSUM_W(14)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_signed(cfg_signed),
        .filtr_load(filtr_load), .filtr_in(filtr_in), .clear(clear),
        .busy(busy), .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic last_acc, last_rdy;
    logic [13:0] got_q[$];

    // Inputs change 1 time unit after posedge; handshake sampled 1 unit later, before the edge.
    task automatic tick();
        #1;
        last_rdy = bus.ifmap_ready;
        last_acc = bus.ifmap_valid && bus.ifmap_ready;
        if (bus.psum_valid && bus.psum_ready) got_q.push_back(bus.psum_out);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] smp, input logic [13:0] ps);
        int n;
        bus.ifmap_valid = 1'b1;
        bus.ifmap_in    = smp;
        bus.psum_in     = ps;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 50);
        bus.ifmap_valid = 1'b0;
        if (!last_acc) begin
            tests++; fails++;
            $display("FAIL send_timeout sample=%0d not accepted within 50 cycles", smp);
        end
    endtask

    task automatic load(input logic [11:0] w, input logic sgn);
        filtr_load = 1'b1;
        filtr_in   = w;
        cfg_signed = sgn;
        tick();
        filtr_load = 1'b0;
        got_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ifmap_valid = 1'b1;
        tick(); tick();
        tests++; if (bus.psum_valid !== 1'b0 || bus.psum_out !== 14'd0 || bus.sat_flag !== 1'b0) begin
            fails++; $display("FAIL reset_outputs got valid=%b out=%0d sat=%b exp 0/0/0", bus.psum_valid, bus.psum_out, bus.sat_flag);
        end
        tests++; if (busy !== 1'b0 || bus.ifmap_shift_vld !== 1'b0 || bus.ifmap_shift_out !== 8'd0) begin
            fails++; $display("FAIL reset_misc got busy=%b shvld=%b shout=%0d exp 0/0/0", busy, bus.ifmap_shift_vld, bus.ifmap_shift_out);
        end
        rst = 1'b0;
        tick();
        tests++; if (last_rdy !== 1'b0) begin
            fails++; $display("FAIL idle_ready got %b exp 0", last_rdy);
        end
        bus.ifmap_valid = 1'b0;
    endtask

    task automatic test_basic();
        load(12'h431, 1'b0);
        send(8'd2, 14'd1); send(8'd4, 14'd1); send(8'd1, 14'd1);
        tests++; if (bus.psum_valid !== 1'b0) begin
            fails++; $display("FAIL basic_latency got valid=%b exp 0 one cycle after issue", bus.psum_valid);
        end
        send(8'd0, 14'd1);
        tests++; if (bus.psum_valid !== 1'b1 || bus.psum_out !== 14'd22) begin
            fails++; $display("FAIL basic_first got valid=%b out=%0d exp 1/22", bus.psum_valid, bus.psum_out);
        end
        tests++; if (bus.ifmap_shift_vld !== 1'b1 || bus.ifmap_shift_out !== 8'd2) begin
            fails++; $display("FAIL basic_shift got vld=%b out=%0d exp 1/2", bus.ifmap_shift_vld, bus.ifmap_shift_out);
        end
        tick();
        tests++; if (bus.psum_valid !== 1'b1 || bus.psum_out !== 14'd20 || bus.ifmap_shift_vld !== 1'b0) begin
            fails++; $display("FAIL basic_second got valid=%b out=%0d shvld=%b exp 1/20/0", bus.psum_valid, bus.psum_out, bus.ifmap_shift_vld);
        end
        tick();
        tests++; if (got_q.size() != 2 || got_q[0] !== 14'd22 || got_q[1] !== 14'd20) begin
            fails++; $display("FAIL basic_stream got %0d results exp 2 (22,20)", got_q.size());
        end
    endtask

    task automatic test_saturation();
        load(12'hFFF, 1'b0);
        send(8'd255, 14'd16383); send(8'd255, 14'd16383); send(8'd255, 14'd16383);
        tick();
        tests++; if (bus.psum_out !== 14'd16383 || bus.sat_flag !== 1'b1) begin
            fails++; $display("FAIL sat_unsigned got out=%0d sat=%b exp 16383/1", bus.psum_out, bus.sat_flag);
        end
        load(12'h777, 1'b1);
        send(8'h80, 14'h2000); send(8'h80, 14'h2000); send(8'h80, 14'h2000);
        tick();
        tests++; if (bus.psum_out !== 14'h2000 || bus.sat_flag !== 1'b1 || bus.psum_valid !== 1'b1) begin
            fails++; $display("FAIL sat_signed got out=%h sat=%b exp 2000/1", bus.psum_out, bus.sat_flag);
        end
        send(8'd1, 14'd0);
        tick();
        tests++; if (bus.psum_out !== 14'h3907 || bus.sat_flag !== 1'b0) begin
            fails++; $display("FAIL signed_noclamp got out=%h sat=%b exp 3907/0", bus.psum_out, bus.sat_flag);
        end
    endtask

    task automatic test_stall();
        logic [13:0] exp_r [10] = '{14'd6, 14'd9, 14'd12, 14'd15, 14'd18, 14'd21, 14'd24, 14'd27, 14'd30, 14'd33};
        logic [13:0] held;
        int idx, bad_rdy, bad_hold;
        load(12'h111, 1'b0);
        idx = 0; bad_rdy = 0; bad_hold = 0; held = '0;
        for (int c = 0; c < 30; c++) begin
            bus.psum_ready  = !(c >= 6 && c <= 9);
            bus.ifmap_valid = (idx < 12);
            bus.ifmap_in    = 8'(idx + 1);
            bus.psum_in     = 14'd0;
            if (c == 6) held = bus.psum_out;
            tick();
            if (last_acc) idx++;
            if (c >= 6 && c <= 9) begin
                if (last_rdy !== 1'b0) bad_rdy++;
                if (bus.psum_out !== held || bus.psum_valid !== 1'b1) bad_hold++;
            end
        end
        bus.ifmap_valid = 1'b0;
        bus.psum_ready  = 1'b1;
        tests++; if (bad_rdy != 0) begin
            fails++; $display("FAIL stall_ready got %0d cycles with ready=1 exp 0", bad_rdy);
        end
        tests++; if (bad_hold != 0 || held !== 14'd12) begin
            fails++; $display("FAIL stall_hold got %0d changes held=%0d exp 0 changes held=12", bad_hold, held);
        end
        tests++; if (got_q.size() != 10) begin
            fails++; $display("FAIL stall_count got %0d results exp 10", got_q.size());
        end
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            tests++; if (got_q[i] !== exp_r[i]) begin
                fails++; $display("FAIL stall_data[%0d] got %0d exp %0d", i, got_q[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_clear();
        load(12'h431, 1'b0);
        send(8'd9, 14'd1); send(8'd9, 14'd1);
        clear = 1'b1;
        bus.ifmap_valid = 1'b1;
        bus.ifmap_in = 8'd7;
        tick();
        clear = 1'b0;
        bus.ifmap_valid = 1'b0;
        tests++; if (last_rdy !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL clear_beat got ready=%b busy=%b exp 0/1", last_rdy, busy);
        end
        send(8'd2, 14'd1); send(8'd4, 14'd1); send(8'd1, 14'd1);
        repeat (4) tick();
        tests++; if (got_q.size() != 1 || got_q[0] !== 14'd22) begin
            fails++; $display("FAIL clear_result got %0d results first=%0d exp 1 result 22", got_q.size(), (got_q.size() > 0) ? got_q[0] : 14'd0);
        end
    endtask

    task automatic test_reload();
        load(12'h111, 1'b0);
        bus.psum_ready = 1'b0;
        send(8'd1, 14'd0); send(8'd2, 14'd0); send(8'd3, 14'd0); send(8'd4, 14'd0);
        tests++; if (bus.psum_valid !== 1'b1 || bus.psum_out !== 14'd6) begin
            fails++; $display("FAIL reload_inflight got valid=%b out=%0d exp 1/6", bus.psum_valid, bus.psum_out);
        end
        filtr_load = 1'b1;
        filtr_in = 12'h222;
        bus.ifmap_valid = 1'b1;
        bus.ifmap_in = 8'd7;
        tick();
        filtr_load = 1'b0;
        bus.ifmap_valid = 1'b0;
        tests++; if (last_rdy !== 1'b0 || bus.psum_valid !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL reload_flush got ready=%b valid=%b busy=%b exp 0/0/1", last_rdy, bus.psum_valid, busy);
        end
        bus.psum_ready = 1'b1;
        tick();
        tests++; if (bus.psum_valid !== 1'b0) begin
            fails++; $display("FAIL reload_s1_drop got valid=%b exp 0", bus.psum_valid);
        end
        send(8'd5, 14'd0); send(8'd5, 14'd0); send(8'd5, 14'd0);
        repeat (4) tick();
        tests++; if (got_q.size() != 1 || got_q[0] !== 14'd30) begin
            fails++; $display("FAIL reload_result got %0d results first=%0d exp 1 result 30", got_q.size(), (got_q.size() > 0) ? got_q[0] : 14'd0);
        end
    endtask

    task automatic test_enable();
        load(12'h111, 1'b0);
        send(8'd1, 14'd0); send(8'd2, 14'd0); send(8'd3, 14'd0);
        en = 1'b0;
        bus.ifmap_valid = 1'b1;
        bus.ifmap_in = 8'd9;
        repeat (3) tick();
        tests++; if (last_rdy !== 1'b0 || bus.psum_valid !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL enable_freeze got ready=%b valid=%b busy=%b exp 0/0/1", last_rdy, bus.psum_valid, busy);
        end
        bus.ifmap_valid = 1'b0;
        en = 1'b1;
        tick();
        tests++; if (bus.psum_valid !== 1'b1 || bus.psum_out !== 14'd6) begin
            fails++; $display("FAIL enable_resume got valid=%b out=%0d exp 1/6", bus.psum_valid, bus.psum_out);
        end
    endtask

    task automatic test_reset_mid();
        load(12'h111, 1'b0);
        bus.psum_ready = 1'b0;
        send(8'd1, 14'd0); send(8'd2, 14'd0); send(8'd3, 14'd0);
        tick();
        tests++; if (bus.psum_valid !== 1'b1) begin
            fails++; $display("FAIL rstmid_pre got valid=%b exp 1", bus.psum_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (bus.psum_valid !== 1'b0 || bus.psum_out !== 14'd0 || busy !== 1'b0 || bus.ifmap_shift_vld !== 1'b0) begin
            fails++; $display("FAIL rstmid_outputs got valid=%b out=%0d busy=%b shvld=%b exp 0/0/0/0", bus.psum_valid, bus.psum_out, busy, bus.ifmap_shift_vld);
        end
        bus.psum_ready = 1'b1;
        bus.ifmap_valid = 1'b1;
        tick(); tick();
        bus.ifmap_valid = 1'b0;
        tests++; if (last_rdy !== 1'b0) begin
            fails++; $display("FAIL rstmid_idle got ready=%b exp 0", last_rdy);
        end
        load(12'h111, 1'b0);
        #1;
        tests++; if (bus.ifmap_ready !== 1'b1) begin
            fails++; $display("FAIL rstmid_reload got ready=%b exp 1", bus.ifmap_ready);
        end
    endtask

    initial begin
        bus.ifmap_valid = 1'b0;
        bus.ifmap_in    = '0;
        bus.psum_in     = '0;
        bus.psum_ready  = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_saturation();
        test_stall();
        test_clear();
        test_reload();
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
